// File: rtl/tt_sweep_pkg.sv
// Shared types and sizing helpers for the truth-table sweeper.
package tt_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    DONE
  } state_t;

  function automatic int ncomb(input int n);
    return 1 << n;
  endfunction

  // A one-cycle dwell still needs a real (1-bit) counter to keep widths legal.
  function automatic int dwell_w(input int dwell);
    return (dwell <= 1) ? 1 : $clog2(dwell);
  endfunction

endpackage

// File: rtl/tt_dwell_timer.sv
// Counts 0..DWELL-1 while enabled; clear wins over enable.
module tt_dwell_timer
  import tt_sweep_pkg::*;
#(
  parameter int DWELL = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic last
);

  localparam int W = dwell_w(DWELL);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

  assign last = (count == W'(DWELL - 1));

endmodule

// File: rtl/truth_table_sweeper.sv
// Walks every input combination of a small combinational block, holding each
// for DWELL cycles, and scores the sampled output against EXPECTED.
module truth_table_sweeper
  import tt_sweep_pkg::*;
#(
  parameter int                     N_IN     = 2,
  parameter int                     DWELL    = 20,
  parameter logic [(1<<N_IN)-1:0]   EXPECTED = 4'b1000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      dut_out,
  output logic [N_IN-1:0]           stim,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [ncomb(N_IN)-1:0]    obs_vec,
  output logic [ncomb(N_IN)-1:0]    err_vec,
  output logic [N_IN:0]             err_cnt
);

  localparam int              NC       = ncomb(N_IN);
  localparam logic [N_IN-1:0] LAST_IDX = N_IN'(NC - 1);

  state_t            state, state_nxt;
  logic [N_IN-1:0]   idx, stim_q;
  logic [NC-1:0]     obs_q, err_q;
  logic [N_IN:0]     cnt_q, cnt_sum;
  logic              pass_q;
  logic              accept, sample, last_comb, err_bit;
  logic              tmr_clear, tmr_en, tmr_last;

  tt_dwell_timer #(.DWELL(DWELL)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (tmr_clear),
    .en    (tmr_en),
    .last  (tmr_last)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // The timer is held cleared outside DRIVE so each sweep starts from dwell 0.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    sample    = 1'b0;
    tmr_clear = 1'b1;
    tmr_en    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = DRIVE;
          accept    = 1'b1;
        end
      end
      DRIVE: begin
        tmr_clear = 1'b0;
        tmr_en    = 1'b1;
        if (tmr_last) begin
          sample    = 1'b1;
          tmr_clear = 1'b1;
          if (last_comb) state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign last_comb = (idx == LAST_IDX);
  assign err_bit   = dut_out ^ EXPECTED[idx];
  assign cnt_sum   = cnt_q + (N_IN + 1)'(err_bit);

  // stim advances on the sampling edge so there is no gap between combinations.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx    <= '0;
      stim_q <= '0;
      obs_q  <= '0;
      err_q  <= '0;
      cnt_q  <= '0;
      pass_q <= 1'b0;
    end else if (accept) begin
      idx    <= '0;
      stim_q <= '0;
      obs_q  <= '0;
      err_q  <= '0;
      cnt_q  <= '0;
      pass_q <= 1'b0;
    end else if (sample) begin
      obs_q[idx] <= dut_out;
      err_q[idx] <= err_bit;
      cnt_q      <= cnt_sum;
      if (last_comb) begin
        pass_q <= (cnt_sum == '0);
      end else begin
        idx    <= idx + N_IN'(1);
        stim_q <= idx + N_IN'(1);
      end
    end else if (state == DONE) begin
      stim_q <= '0;
    end
  end

  assign stim    = stim_q;
  assign busy    = (state == DRIVE);
  assign done    = (state == DONE);
  assign pass    = pass_q;
  assign obs_vec = obs_q;
  assign err_vec = err_q;
  assign err_cnt = cnt_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Randomized self-checking bench: two sweeper instances (2-input/DWELL 20 and
// 3-input/DWELL 1) driven by truth-table models of the block under test.
module tb_truth_table_sweeper;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_a, start_b;
  logic [3:0] tt_a;
  logic [7:0] tt_b;
  logic       dut_out_a, dut_out_b;

  logic [1:0] stim_a;
  logic [2:0] stim_b;
  logic       busy_a, done_a, pass_a, busy_b, done_b, pass_b;
  logic [3:0] obs_a, err_a;
  logic [7:0] obs_b, err_b;
  logic [2:0] cnt_a;
  logic [3:0] cnt_b;

  logic       sel;
  logic [7:0] m_stim, m_obs, m_err;
  logic [3:0] m_cnt;
  logic       m_busy, m_done, m_pass;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [31:0] last_res;

  always #5 clk = ~clk;

  assign dut_out_a = tt_a[stim_a];
  assign dut_out_b = tt_b[stim_b];

  truth_table_sweeper u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .dut_out(dut_out_a),
    .stim(stim_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .obs_vec(obs_a), .err_vec(err_a), .err_cnt(cnt_a)
  );

  truth_table_sweeper #(.N_IN(3), .DWELL(1), .EXPECTED(8'b10010110)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .dut_out(dut_out_b),
    .stim(stim_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .obs_vec(obs_b), .err_vec(err_b), .err_cnt(cnt_b)
  );

  assign m_stim = sel ? {5'b0, stim_b} : {6'b0, stim_a};
  assign m_obs  = sel ? obs_b : {4'b0, obs_a};
  assign m_err  = sel ? err_b : {4'b0, err_a};
  assign m_cnt  = sel ? cnt_b : {1'b0, cnt_a};
  assign m_busy = sel ? busy_b : busy_a;
  assign m_done = sel ? done_b : done_a;
  assign m_pass = sel ? pass_b : pass_a;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h (t=%0t)",
               tag, observed, expected, $time);
    end
  endtask

  task automatic driveStart(input logic v);
    if (sel) start_b = v;
    else     start_a = v;
  endtask

  function automatic logic [7:0] xorTable();
    logic [7:0] t;
    for (int k = 0; k < 8; k++) t[k] = ^(3'(k));
    return t;
  endfunction

  // One full sweep from an idle cycle; poke_at>0 pulses start mid-sweep and
  // again in the done cycle, both of which must be ignored.
  task automatic applyStimulus(input bit use_b, input logic [7:0] tt,
                               input int poke_at);
    int         nc, dw, cnt_exp;
    logic [7:0] exp_tt, obs_exp, err_exp;
    logic [31:0] res_exp;
    nc     = use_b ? 8 : 4;
    dw     = use_b ? 1 : 20;
    exp_tt = use_b ? xorTable() : 8'h08;
    sel    = use_b;
    if (use_b) tt_b = tt;
    else       tt_a = tt[3:0];
    obs_exp = '0;
    cnt_exp = 0;
    for (int k = 0; k < nc; k++) obs_exp[k] = tt[k];
    err_exp = obs_exp ^ exp_tt;
    for (int k = 0; k < nc; k++) cnt_exp += int'(err_exp[k]);
    res_exp = 32'({obs_exp, err_exp, 4'(cnt_exp), (cnt_exp == 0)});

    driveStart(1'b1);
    @(negedge clk);
    driveStart(1'b0);
    checkOutput("cleared", 32'({m_obs, m_err, m_cnt, m_pass}), 32'd0);
    for (int c = 1; c <= nc * dw; c++) begin
      checkOutput("drive", 32'({m_busy, m_done, m_stim}),
                  32'({1'b1, 1'b0, 8'((c - 1) / dw)}));
      driveStart(poke_at == c);
      @(negedge clk);
    end
    driveStart(1'b0);
    checkOutput("done_pulse", 32'({m_busy, m_done}), 32'b01);
    checkOutput("obs_vec", 32'(m_obs), 32'(obs_exp));
    checkOutput("err_vec", 32'(m_err), 32'(err_exp));
    checkOutput("err_cnt", 32'(m_cnt), 32'(cnt_exp));
    checkOutput("pass", 32'(m_pass), 32'(cnt_exp == 0));
    driveStart(poke_at != 0);
    @(negedge clk);
    driveStart(1'b0);
    checkOutput("post_done", 32'({m_busy, m_done, m_stim}), 32'd0);
    checkOutput("held", 32'({m_obs, m_err, m_cnt, m_pass}), res_exp);
    last_res = res_exp;
  endtask

  task automatic holdCheck(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      checkOutput("hold", 32'({m_busy, m_done, m_obs, m_err, m_cnt, m_pass}),
                  {9'b0, 2'b00, last_res[20:0]});
    end
  endtask

  task automatic resetMidSweep();
    sel     = 1'b0;
    tt_a    = 4'b1000;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (44) @(negedge clk);
    checkOutput("mid_stim", 32'(stim_a), 32'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_mid", 32'({stim_a, busy_a, done_a, pass_a, obs_a, err_a, cnt_a}), 32'd0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      checkOutput("rst_idle", 32'({busy_a, done_a, stim_a}), 32'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0] rtt;
    int         gap, pk;
    bit         ub;
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
    tt_a = 4'b1000; tt_b = xorTable(); sel = 1'b0; last_res = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_a", 32'({stim_a, busy_a, done_a, pass_a, obs_a, err_a, cnt_a}), 32'd0);
    checkOutput("reset_b", 32'({stim_b, busy_b, done_b, pass_b, obs_b, err_b, cnt_b}), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] AND block with ignored start pulses");
    applyStimulus(1'b0, 8'h08, 20);
    $display("[TB] OR block, back-to-back start");
    applyStimulus(1'b0, 8'h0E, 0);
    $display("[TB] stuck-at-1 block, results held");
    applyStimulus(1'b0, 8'h0F, 0);
    holdCheck(50);
    $display("[TB] reset during combination 2");
    resetMidSweep();
    applyStimulus(1'b0, 8'h08, 0);
    $display("[TB] 3-input XOR, DWELL=1");
    applyStimulus(1'b1, xorTable(), 0);
    holdCheck(5);

    $display("[TB] randomized sweeps");
    for (int it = 0; it < 10; it++) begin
      ub  = 1'($urandom_range(0, 1));
      rtt = 8'($urandom);
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge clk);
      pk  = ($urandom_range(0, 1) == 1) ? $urandom_range(1, ub ? 8 : 80) : 0;
      applyStimulus(ub, rtt, pk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
